// File: rtl/hardwired_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : hardwired_control_unit
// Description : Hardwired T-state sequencer for the ALU datapath system.
//               T0/T1 fetch the low/high instruction byte from M[PC] into IR,
//               T2/T3 execute the opcode held in IR_Out[15:12]. All control
//               outputs are a combinational decode of (state, SC, IR, flags);
//               the datapath loads on the same rising edge that advances SC.
//
// Parameters  : CLEAR_ON_RESET - 1: an INIT cycle after reset clears PC/AR/SP,
//                                R1-R4 and T1-T4; 0: reset goes straight to T0.
// Optional    : `define CU_RETIRE_CNT_EN adds Retired[15:0], a saturating count
//               of completed instructions (HLT included, INIT excluded).
//
// Ports       : Clock, Reset (sync, active-high)
//               IR_Out[15:0]   - {opcode[15:12], -, Rx[9:8], -, Ry[5:4], -}
//               ALU_Flags[3:0] - {Z,C,N,O}
//               RF_*, ARF_*, ALU_FunSel, IR_*, Mem_*, Mux* - datapath controls
//               Halted         - high in HALT
//               SC[1:0]        - current T-state
//
// Revision    : 1.0 - initial release
// ============================================================================
module hardwired_control_unit #(
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [15:0] IR_Out,
    input  logic [3:0]  ALU_Flags,
    output logic [2:0]  RF_O1Sel,
    output logic [2:0]  RF_O2Sel,
    output logic [1:0]  RF_FunSel,
    output logic [3:0]  RF_RegSel,
    output logic [3:0]  RF_TSel,
    output logic [3:0]  ALU_FunSel,
    output logic [1:0]  ARF_OutASel,
    output logic [1:0]  ARF_OutBSel,
    output logic [1:0]  ARF_FunSel,
    output logic [2:0]  ARF_RegSel,
    output logic        IR_LH,
    output logic        IR_Enable,
    output logic [1:0]  IR_Funsel,
    output logic        Mem_WR,
    output logic        Mem_CS,
    output logic [1:0]  MuxSelA,
    output logic [1:0]  MuxSelB,
    output logic        MuxCSel,
    output logic        Halted,
`ifdef CU_RETIRE_CNT_EN
    output logic [15:0] Retired,
`endif
    output logic [1:0]  SC
);

    typedef enum logic [1:0] {
        S_INIT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    localparam logic [3:0] OP_LDI = 4'h0;
    localparam logic [3:0] OP_LD  = 4'h1;
    localparam logic [3:0] OP_ST  = 4'h2;
    localparam logic [3:0] OP_ADD = 4'h3;
    localparam logic [3:0] OP_INC = 4'h4;
    localparam logic [3:0] OP_BEQ = 4'h5;
    localparam logic [3:0] OP_BRA = 4'h6;
    localparam logic [3:0] OP_HLT = 4'hF;

    state_t     state;
    logic [1:0] sc;

    logic [3:0] opcode;
    logic [1:0] rx;
    logic [1:0] ry;
    logic [3:0] rx_sel;
    logic       is_mem_op;
    logic       last_cycle;

    assign opcode    = IR_Out[15:12];
    assign rx        = IR_Out[9:8];
    assign ry        = IR_Out[5:4];
    // One-hot active-low enable for Rx (R1 = bit 0)
    assign rx_sel    = ~(4'b0001 << rx);
    assign is_mem_op = (opcode == OP_LD) || (opcode == OP_ST);
    // LD/ST need a memory cycle at T3; everything else retires at T2
    assign last_cycle = (sc == 2'd3) || ((sc == 2'd2) && !is_mem_op);

    // Address/immediate bits are consumed by the datapath, not here
    logic unused_inputs;
    assign unused_inputs = ^{IR_Out[11:10], IR_Out[7:6], IR_Out[3:0], ALU_Flags[2:0]};

    // ------------------------------------------------------------------
    // Sequencer state
    // ------------------------------------------------------------------
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= CLEAR_ON_RESET ? S_INIT : S_RUN;
            sc    <= 2'd0;
        end else begin
            case (state)
                S_INIT: begin
                    state <= S_RUN;
                    sc    <= 2'd0;
                end
                S_RUN: begin
                    if (last_cycle) begin
                        sc <= 2'd0;
                        if (sc == 2'd2 && opcode == OP_HLT)
                            state <= S_HALT;
                    end else begin
                        sc <= sc + 2'd1;
                    end
                end
                S_HALT: begin
                    state <= S_HALT;
                    sc    <= sc;
                end
                default: begin
                    state <= S_INIT;
                    sc    <= 2'd0;
                end
            endcase
        end
    end

`ifdef CU_RETIRE_CNT_EN
    logic [15:0] retired_cnt;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            retired_cnt <= 16'd0;
        end else if (state == S_RUN && last_cycle && retired_cnt != 16'hFFFF) begin
            retired_cnt <= retired_cnt + 16'd1;
        end
    end

    assign Retired = retired_cnt;
`endif

    // ------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------
    always_comb begin
        RF_O1Sel    = 3'd0;
        RF_O2Sel    = 3'd0;
        RF_FunSel   = 2'd0;
        RF_RegSel   = 4'b1111;
        RF_TSel     = 4'b1111;
        ALU_FunSel  = 4'd0;
        ARF_OutASel = 2'd0;
        ARF_OutBSel = 2'd0;
        ARF_FunSel  = 2'd0;
        ARF_RegSel  = 3'b111;
        IR_LH       = 1'b0;
        IR_Enable   = 1'b0;
        IR_Funsel   = 2'd0;
        Mem_WR      = 1'b0;
        Mem_CS      = 1'b1;
        MuxSelA     = 2'd0;
        MuxSelB     = 2'd0;
        MuxCSel     = 1'b0;
        Halted      = 1'b0;
        SC          = 2'd0;

        if (!Reset) begin
            SC = sc;
            case (state)
                S_INIT: begin
                    // Clear every register in both files
                    RF_RegSel  = 4'b0000;
                    RF_TSel    = 4'b0000;
                    ARF_RegSel = 3'b000;
                end
                S_HALT: begin
                    Halted = 1'b1;
                end
                S_RUN: begin
                    case (sc)
                        2'd0, 2'd1: begin
                            // Fetch byte from M[PC] into IR, then PC <= PC + 1
                            ARF_OutBSel = 2'b11;
                            Mem_CS      = 1'b0;
                            IR_Enable   = 1'b1;
                            IR_LH       = (sc == 2'd1);
                            IR_Funsel   = 2'b01;
                            ARF_RegSel  = 3'b110;
                            ARF_FunSel  = 2'b11;
                        end
                        2'd2: begin
                            case (opcode)
                                OP_LDI: begin
                                    MuxSelA   = 2'b10;
                                    RF_FunSel = 2'b01;
                                    RF_RegSel = rx_sel;
                                end
                                OP_LD, OP_ST: begin
                                    // AR <= IR[7:0]
                                    MuxSelB    = 2'b10;
                                    ARF_FunSel = 2'b01;
                                    ARF_RegSel = 3'b101;
                                end
                                OP_ADD: begin
                                    RF_O1Sel   = {1'b1, rx};
                                    RF_O2Sel   = {1'b1, ry};
                                    MuxCSel    = 1'b1;
                                    ALU_FunSel = 4'b0100;
                                    MuxSelA    = 2'b00;
                                    RF_FunSel  = 2'b01;
                                    RF_RegSel  = rx_sel;
                                end
                                OP_INC: begin
                                    RF_FunSel = 2'b11;
                                    RF_RegSel = rx_sel;
                                end
                                OP_BEQ, OP_BRA: begin
                                    // PC <= IR[7:0]; BEQ only when Z is set
                                    if (opcode == OP_BRA || ALU_Flags[3]) begin
                                        MuxSelB    = 2'b10;
                                        ARF_FunSel = 2'b01;
                                        ARF_RegSel = 3'b110;
                                    end
                                end
                                default: ; // HLT and NOP codes are idle here
                            endcase
                        end
                        2'd3: begin
                            if (opcode == OP_LD) begin
                                ARF_OutBSel = 2'b00;
                                Mem_CS      = 1'b0;
                                MuxSelA     = 2'b01;
                                RF_FunSel   = 2'b01;
                                RF_RegSel   = rx_sel;
                            end else if (opcode == OP_ST) begin
                                // Rx passes through the ALU onto the memory bus
                                RF_O1Sel    = {1'b1, rx};
                                MuxCSel     = 1'b1;
                                ALU_FunSel  = 4'b0000;
                                ARF_OutBSel = 2'b00;
                                Mem_CS      = 1'b0;
                                Mem_WR      = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hardwired_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_hardwired_control_unit
// Description : Directed self-checking bench for hardwired_control_unit with
//               hand-computed expected control words.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hardwired_control_unit;

    logic        Clock;
    logic        Reset;
    logic [15:0] IR_Out;
    logic [3:0]  ALU_Flags;
    logic [2:0]  RF_O1Sel, RF_O2Sel;
    logic [1:0]  RF_FunSel;
    logic [3:0]  RF_RegSel, RF_TSel;
    logic [3:0]  ALU_FunSel;
    logic [1:0]  ARF_OutASel, ARF_OutBSel, ARF_FunSel;
    logic [2:0]  ARF_RegSel;
    logic        IR_LH, IR_Enable;
    logic [1:0]  IR_Funsel;
    logic        Mem_WR, Mem_CS;
    logic [1:0]  MuxSelA, MuxSelB;
    logic        MuxCSel;
    logic        Halted;
    logic [1:0]  SC;
`ifdef CU_RETIRE_CNT_EN
    logic [15:0] Retired;
`endif

    int n_cmp = 0;
    int n_err = 0;

    hardwired_control_unit #(.CLEAR_ON_RESET(1'b1)) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .IR_Out      (IR_Out),
        .ALU_Flags   (ALU_Flags),
        .RF_O1Sel    (RF_O1Sel),
        .RF_O2Sel    (RF_O2Sel),
        .RF_FunSel   (RF_FunSel),
        .RF_RegSel   (RF_RegSel),
        .RF_TSel     (RF_TSel),
        .ALU_FunSel  (ALU_FunSel),
        .ARF_OutASel (ARF_OutASel),
        .ARF_OutBSel (ARF_OutBSel),
        .ARF_FunSel  (ARF_FunSel),
        .ARF_RegSel  (ARF_RegSel),
        .IR_LH       (IR_LH),
        .IR_Enable   (IR_Enable),
        .IR_Funsel   (IR_Funsel),
        .Mem_WR      (Mem_WR),
        .Mem_CS      (Mem_CS),
        .MuxSelA     (MuxSelA),
        .MuxSelB     (MuxSelB),
        .MuxCSel     (MuxCSel),
        .Halted      (Halted),
`ifdef CU_RETIRE_CNT_EN
        .Retired     (Retired),
`endif
        .SC          (SC)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one cycle and settle just after the edge
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic fetch(input logic [15:0] instr);
        // At T0 on entry; T0 and T1 then land on T2
        check("fetch_t0_sc", 16'(SC), 16'd0);
        check("fetch_t0_lh", 16'(IR_LH), 16'd0);
        tick();
        check("fetch_t1_lh", 16'(IR_LH), 16'd1);
        check("fetch_t1_en", 16'(IR_Enable), 16'd1);
        IR_Out = instr;
        tick();
        #1;
        check("exec_t2_sc", 16'(SC), 16'd2);
    endtask

    initial begin
        Reset     = 1'b1;
        IR_Out    = 16'h0000;
        ALU_Flags = 4'b0000;

        tick();
        tick();
        check("rst_rfreg",  16'(RF_RegSel),  16'hF);
        check("rst_arfreg", 16'(ARF_RegSel), 16'h7);
        check("rst_memcs",  16'(Mem_CS),     16'd1);
        check("rst_sc",     16'(SC),         16'd0);
`ifdef CU_RETIRE_CNT_EN
        check("rst_retired", Retired, 16'd0);
`endif
        Reset = 1'b0;
        #1;
        // INIT cycle clears all registers
        check("init_arfreg", 16'(ARF_RegSel), 16'h0);
        check("init_rfreg",  16'(RF_RegSel),  16'h0);
        check("init_tsel",   16'(RF_TSel),    16'h0);
        check("init_funsel", {12'd0, RF_FunSel, ARF_FunSel}, 16'h0);
        tick();
        check("t0_bsel",  16'(ARF_OutBSel), 16'h3);
        check("t0_iren",  16'(IR_Enable),   16'd1);
        check("t0_arf",   {ARF_FunSel, 1'b0, ARF_RegSel}, {2'b11, 1'b0, 3'b110});
        check("t0_mem",   {14'd0, Mem_CS, Mem_WR}, 16'd0);

        // LDI R2, 0x5A
        fetch(16'h015A);
        check("ldi_muxa",  16'(MuxSelA),   16'h2);
        check("ldi_rffun", 16'(RF_FunSel), 16'h1);
        check("ldi_rfreg", 16'(RF_RegSel), 16'hD);
        tick();
        check("ldi_sc_wrap", 16'(SC), 16'd0);

        // ST R4 -> 0x44
        fetch(16'h2344);
        check("st_t2_muxb",   16'(MuxSelB),    16'h2);
        check("st_t2_arfreg", 16'(ARF_RegSel), 16'h5);
        check("st_t2_arffun", 16'(ARF_FunSel), 16'h1);
        tick();
        check("st_t3_o1",   16'(RF_O1Sel), 16'd7);
        check("st_t3_wr",   16'(Mem_WR),   16'd1);
        check("st_t3_cs",   16'(Mem_CS),   16'd0);
        check("st_t3_muxc", 16'(MuxCSel),  16'd1);
        check("st_t3_bsel", 16'(ARF_OutBSel), 16'd0);
        tick();
        check("st_sc_wrap", 16'(SC), 16'd0);

        // BEQ 0x20, taken then not taken
        ALU_Flags = 4'b1000;
        fetch(16'h5020);
        check("beq_t_arffun", 16'(ARF_FunSel), 16'h1);
        check("beq_t_arfreg", 16'(ARF_RegSel), 16'h6);
        check("beq_t_muxb",   16'(MuxSelB),    16'h2);
        ALU_Flags = 4'b0000;
        #1;
        check("beq_nt_arfreg", 16'(ARF_RegSel), 16'h7);
        check("beq_nt_muxb",   16'(MuxSelB),    16'h0);
        tick();

        // ADD R2 <- R2 + R3
        fetch(16'h3120);
        check("add_o1",    16'(RF_O1Sel),   16'd5);
        check("add_o2",    16'(RF_O2Sel),   16'd6);
        check("add_alu",   16'(ALU_FunSel), 16'h4);
        check("add_rfreg", 16'(RF_RegSel),  16'hD);
        tick();

        // HLT
        fetch(16'hF000);
        check("hlt_t2_halted", 16'(Halted), 16'd0);
        check("hlt_t2_cs",     16'(Mem_CS), 16'd1);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("halt_halted", 16'(Halted),     16'd1);
            check("halt_sc",     16'(SC),         16'd0);
            check("halt_iren",   16'(IR_Enable),  16'd0);
            check("halt_arfreg", 16'(ARF_RegSel), 16'h7);
        end
`ifdef CU_RETIRE_CNT_EN
        // LDI, ST, BEQ, ADD, HLT
        check("retired_5", Retired, 16'd5);
`endif
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        #1;
        check("exit_halt_init", 16'(ARF_RegSel), 16'h0);
        check("exit_halt_flag", 16'(Halted),     16'd0);
        tick();

        // LD R1 <- M[0x10], aborted by reset at T3
        fetch(16'h1010);
        check("ld_t2_arfreg", 16'(ARF_RegSel), 16'h5);
        tick();
        check("ld_t3_cs",    16'(Mem_CS),    16'd0);
        check("ld_t3_muxa",  16'(MuxSelA),   16'h1);
        check("ld_t3_rfreg", 16'(RF_RegSel), 16'hE);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        #1;
        check("ld_abort_init", 16'(ARF_RegSel), 16'h0);
        check("ld_abort_sc",   16'(SC),         16'd0);
`ifdef CU_RETIRE_CNT_EN
        check("ld_abort_retired", Retired, 16'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
